// File: rtl/relay_pkg.sv
// -----------------------------------------------------------------------------
// relay_pkg
// Shared definitions for the relay-station stream converters.
//   - clog2        : constant-expression ceiling log2, used for derived widths
//   - RELAY_*      : default narrow width and packing ratio
//   - ratio_legal  : legality test for RATIO, used by elaboration checks
// No ports (package).
// -----------------------------------------------------------------------------
package relay_pkg;

    localparam int RELAY_IN_WIDTH  = 32;
    localparam int RELAY_RATIO     = 4;
    localparam int RELAY_RATIO_MIN = 2;
    localparam int RELAY_RATIO_MAX = 64;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic bit ratio_legal(input int ratio);
        return (ratio >= RELAY_RATIO_MIN) && (ratio <= RELAY_RATIO_MAX);
    endfunction

endpackage

// File: rtl/relay_upsizer_acc.sv
// -----------------------------------------------------------------------------
// relay_upsizer_acc
// Lane counter and accumulator for relay_upsizer. Collects narrow words into
// lanes 0..RATIO-2 and presents the completed wide vector combinationally in
// the cycle the closing word is accepted.
// Optional feature: RELAY_UPSIZER_EOT_EN (bit IN_WIDTH-1 closes a short word).
// Ports:
//   clk, reset_n  : clock, synchronous active-low reset
//   accept        : narrow word on in_dout is consumed this cycle
//   in_dout       : narrow word
//   last_lane     : counter sits on the final lane
//   eot           : head word carries the end-of-transfer flag
//   complete      : this accept closes a wide word
//   wide_vec      : {in_dout, accumulator} with lanes above the current one zeroed
//   wide_count    : valid lanes in wide_vec (current lane + 1)
// -----------------------------------------------------------------------------
module relay_upsizer_acc
    import relay_pkg::*;
#(
    parameter  int IN_WIDTH  = RELAY_IN_WIDTH,
    parameter  int RATIO     = RELAY_RATIO,
    localparam int CNT_WIDTH = clog2(RATIO + 1)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             accept,
    input  logic [IN_WIDTH-1:0]              in_dout,
    output logic                             last_lane,
    output logic                             eot,
    output logic                             complete,
    output logic [RATIO-1:0][IN_WIDTH-1:0]   wide_vec,
    output logic [CNT_WIDTH-1:0]             wide_count
);

    localparam int                LANE_W    = clog2(RATIO);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    logic [LANE_W-1:0]                 lane_q, lane_d;
    logic [RATIO-2:0][IN_WIDTH-1:0]    acc_q, acc_d;

`ifdef RELAY_UPSIZER_EOT_EN
    assign eot = in_dout[IN_WIDTH-1];
`else
    assign eot = 1'b0;
`endif

    assign last_lane  = (lane_q == LAST_LANE);
    assign complete   = accept & (last_lane | eot);
    assign wide_count = CNT_WIDTH'(lane_q) + CNT_WIDTH'(1);

    always_comb begin
        lane_d = lane_q;
        acc_d  = acc_q;
        if (accept) begin
            if (complete) begin
                // Stale lanes are left in place; they are overwritten before reuse.
                lane_d = '0;
            end else begin
                lane_d = lane_q + LANE_W'(1);
                for (int i = 0; i < RATIO - 1; i++) begin
                    if (lane_q == LANE_W'(i)) begin
                        acc_d[i] = in_dout;
                    end
                end
            end
        end
    end

    // Lanes below the current one come from the accumulator, the current lane
    // is the incoming word, anything above is zero (only reachable on EOT).
    always_comb begin
        for (int i = 0; i < RATIO - 1; i++) begin
            wide_vec[i] = (LANE_W'(i) < lane_q) ? acc_q[i] : '0;
        end
        wide_vec[RATIO-1] = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (LANE_W'(i) == lane_q) begin
                wide_vec[i] = in_dout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lane_q <= '0;
            acc_q  <= '0;
        end else begin
            lane_q <= lane_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/relay_upsizer.sv
// -----------------------------------------------------------------------------
// relay_upsizer
// Packs RATIO consecutive narrow words from an upstream FWFT port into one
// wide word presented on a downstream FWFT port, one narrow word per cycle.
// Optional feature: RELAY_UPSIZER_EOT_EN -- a narrow word with bit IN_WIDTH-1
// set closes the wide word early (out_count reports the valid lanes).
// Ports:
//   clk, reset_n  : clock, synchronous active-low reset
//   in_empty_n    : upstream has a head word
//   in_read       : combinational acknowledge of in_dout
//   in_dout       : upstream head word
//   out_empty_n   : out_dout holds a valid wide word
//   out_read      : downstream consumes out_dout
//   out_dout      : packed word, lane 0 in the low bits
//   out_count     : valid lanes in out_dout
// -----------------------------------------------------------------------------
module relay_upsizer
    import relay_pkg::*;
#(
    parameter  int IN_WIDTH  = RELAY_IN_WIDTH,
    parameter  int RATIO     = RELAY_RATIO,
    localparam int OUT_WIDTH = IN_WIDTH * RATIO,
    localparam int CNT_WIDTH = clog2(RATIO + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_empty_n,
    output logic                  in_read,
    input  logic [IN_WIDTH-1:0]   in_dout,
    output logic                  out_empty_n,
    input  logic                  out_read,
    output logic [OUT_WIDTH-1:0]  out_dout,
    output logic [CNT_WIDTH-1:0]  out_count
);

    if (!ratio_legal(RATIO)) begin : g_bad_ratio
        $error("relay_upsizer: RATIO must be within 2..64");
    end

    logic                            last_lane;
    logic                            eot;
    logic                            complete;
    logic                            stall;
    logic [RATIO-1:0][IN_WIDTH-1:0]  wide_vec;
    logic [CNT_WIDTH-1:0]            wide_count;

    logic                  out_empty_n_q, out_empty_n_d;
    logic [OUT_WIDTH-1:0]  out_dout_q,    out_dout_d;
    logic [CNT_WIDTH-1:0]  out_count_q,   out_count_d;

    // A word that would close a wide word must wait while the output register
    // is occupied and not being drained this cycle.
    assign stall   = out_empty_n_q & ~out_read & (last_lane | eot);
    assign in_read = reset_n & in_empty_n & ~stall;

    relay_upsizer_acc #(
        .IN_WIDTH (IN_WIDTH),
        .RATIO    (RATIO)
    ) u_acc (
        .clk        (clk),
        .reset_n    (reset_n),
        .accept     (in_read),
        .in_dout    (in_dout),
        .last_lane  (last_lane),
        .eot        (eot),
        .complete   (complete),
        .wide_vec   (wide_vec),
        .wide_count (wide_count)
    );

    always_comb begin
        out_empty_n_d = out_empty_n_q;
        out_dout_d    = out_dout_q;
        out_count_d   = out_count_q;
        if (out_read && out_empty_n_q) begin
            out_empty_n_d = 1'b0;
        end
        // A load wins over a same-cycle drain, keeping full throughput.
        if (complete) begin
            out_empty_n_d = 1'b1;
            out_dout_d    = wide_vec;
            out_count_d   = wide_count;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_empty_n_q <= 1'b0;
            out_dout_q    <= '0;
            out_count_q   <= '0;
        end else begin
            out_empty_n_q <= out_empty_n_d;
            out_dout_q    <= out_dout_d;
            out_count_q   <= out_count_d;
        end
    end

    assign out_empty_n = out_empty_n_q;
    assign out_dout    = out_dout_q;
    assign out_count   = out_count_q;

endmodule

// File: tb/tb_relay_upsizer.sv
`timescale 1ns/1ps
module tb_relay_upsizer;

    localparam int IW = 32;
    localparam int R  = 4;
    localparam int OW = IW * R;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_empty_n = 1'b0;
    logic          in_read;
    logic [IW-1:0] in_dout = '0;
    logic          out_empty_n;
    logic          out_read = 1'b0;
    logic [OW-1:0] out_dout;
    logic [CW-1:0] out_count;

    relay_upsizer #(.IN_WIDTH(IW), .RATIO(R)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_empty_n  (in_empty_n),
        .in_read     (in_read),
        .in_dout     (in_dout),
        .out_empty_n (out_empty_n),
        .out_read    (out_read),
        .out_dout    (out_dout),
        .out_count   (out_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: accepted narrow words in order; every R of them form
    // one expected wide word, lane 0 = oldest.
    logic [IW-1:0] narrow_q[$];
    logic [OW-1:0] wide_q[$];
    logic          acc_s, rd_s, rd_known;
    logic [OW-1:0] rd_exp;

    function automatic logic [IW-1:0] rword();
        logic [IW-1:0] w;
        w = $urandom;
`ifdef RELAY_UPSIZER_EOT_EN
        w[IW-1] = 1'b0;
`endif
        return w;
    endfunction

    // Drive one cycle's inputs at the falling edge, then record what the next
    // rising edge will do (accept / drain) and update the model.
    task automatic drive(input logic rn, input logic ien, input logic [IW-1:0] d, input logic ord);
        logic [OW-1:0] packed_w;
        @(negedge clk);
        reset_n = rn; in_empty_n = ien; in_dout = d; out_read = ord;
        #1;
        acc_s    = in_read;
        rd_s     = rn & out_read & out_empty_n;
        rd_known = 1'b0;
        rd_exp   = '0;
        if (!rn) begin
            narrow_q.delete();
            wide_q.delete();
        end else begin
            if (rd_s && wide_q.size() > 0) begin
                rd_exp   = wide_q.pop_front();
                rd_known = 1'b1;
            end
            if (acc_s) begin
                narrow_q.push_back(d);
                if (narrow_q.size() == R) begin
                    packed_w = '0;
                    for (int i = 0; i < R; i++) packed_w[i*IW +: IW] = narrow_q.pop_front();
                    wide_q.push_back(packed_w);
                end
            end
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, rword(), 1'b1);
        drive(1'b0, 1'b1, rword(), 1'b1);
        checks++; if (out_empty_n !== 1'b0) $display("FAIL reset_empty_n: got %b want 0", out_empty_n); else passes++;
        checks++; if (out_dout !== '0) $display("FAIL reset_dout: got %h want 0", out_dout); else passes++;
        checks++; if (out_count !== '0) $display("FAIL reset_count: got %0d want 0", out_count); else passes++;
        checks++; if (acc_s !== 1'b0) $display("FAIL reset_in_read: got %b want 0", acc_s); else passes++;
    endtask

    task automatic test_basic();
        logic [OW-1:0] exp_w;
        exp_w = 128'h00000044_00000033_00000022_00000011;
        drive(1'b1, 1'b1, 32'h11, 1'b1);
        drive(1'b1, 1'b1, 32'h22, 1'b1);
        drive(1'b1, 1'b1, 32'h33, 1'b1);
        drive(1'b1, 1'b1, 32'h44, 1'b1);
        checks++; if (out_empty_n !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", out_empty_n); else passes++;
        drive(1'b1, 1'b0, '0, 1'b1);
        checks++; if (out_empty_n !== 1'b1) $display("FAIL basic_valid: got %b want 1", out_empty_n); else passes++;
        checks++; if (out_dout !== exp_w) $display("FAIL basic_dout: got %h want %h", out_dout, exp_w); else passes++;
        checks++; if (out_count !== CW'(4)) $display("FAIL basic_count: got %0d want 4", out_count); else passes++;
        checks++; if (!rd_known || out_dout !== rd_exp) $display("FAIL basic_model: got %h want %h", out_dout, rd_exp); else passes++;
        drive(1'b1, 1'b0, '0, 1'b0);
        checks++; if (out_empty_n !== 1'b0) $display("FAIL basic_drained: got %b want 0", out_empty_n); else passes++;
    endtask

    task automatic test_back_to_back();
        int rc[$];
        int drops;
        drops = 0;
        for (int c = 0; c < 20; c++) begin
            if (c < 16) drive(1'b1, 1'b1, rword(), 1'b1);
            else        drive(1'b1, 1'b0, '0, 1'b1);
            if (c < 16 && !acc_s) drops++;
            if (rd_s) begin
                rc.push_back(c);
                checks++;
                if (!rd_known || out_dout !== rd_exp) $display("FAIL b2b_data: got %h want %h", out_dout, rd_exp); else passes++;
            end
        end
        checks++; if (drops != 0) $display("FAIL b2b_in_read_drops: got %0d want 0", drops); else passes++;
        checks++; if (rc.size() != 4) $display("FAIL b2b_words: got %0d want 4", rc.size()); else passes++;
        if (rc.size() > 0) begin
            checks++; if (rc[0] != 4) $display("FAIL b2b_first_cycle: got %0d want 4", rc[0]); else passes++;
        end
        for (int i = 1; i < rc.size(); i++) begin
            checks++; if (rc[i] - rc[i-1] != 4) $display("FAIL b2b_spacing: got %0d want 4", rc[i] - rc[i-1]); else passes++;
        end
    endtask

    task automatic test_backpressure();
        int accepts;
        logic [IW-1:0] w7;
        accepts = 0;
        for (int c = 0; c < 4; c++) drive(1'b1, 1'b1, rword(), 1'b0);
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b1, rword(), 1'b0);
            if (acc_s) accepts++;
        end
        checks++; if (accepts != 3) $display("FAIL bp_accepts: got %0d want 3", accepts); else passes++;
        w7 = rword();
        drive(1'b1, 1'b1, w7, 1'b0);
        checks++; if (acc_s !== 1'b0) $display("FAIL bp_stall: got %b want 0", acc_s); else passes++;
        drive(1'b1, 1'b1, w7, 1'b1);
        checks++; if (acc_s !== 1'b1) $display("FAIL bp_release: got %b want 1", acc_s); else passes++;
        checks++; if (!rd_s || !rd_known || out_dout !== rd_exp) $display("FAIL bp_word1: got %h want %h", out_dout, rd_exp); else passes++;
        drive(1'b1, 1'b0, '0, 1'b1);
        checks++; if (!rd_s || !rd_known || out_dout !== rd_exp) $display("FAIL bp_word2: got %h want %h", out_dout, rd_exp); else passes++;
        drive(1'b1, 1'b0, '0, 1'b0);
        checks++; if (out_empty_n !== 1'b0) $display("FAIL bp_drained: got %b want 0", out_empty_n); else passes++;
    endtask

    task automatic test_reset_mid();
        logic [OW-1:0] exp_w;
        exp_w = 128'h000000A3_000000A2_000000A1_000000A0;
        for (int c = 0; c < 6; c++) drive(1'b1, 1'b1, rword(), 1'b0);
        drive(1'b0, 1'b1, rword(), 1'b1);
        checks++; if (acc_s !== 1'b0) $display("FAIL rmid_in_read: got %b want 0", acc_s); else passes++;
        drive(1'b1, 1'b1, 32'hA0, 1'b0);
        checks++; if (out_empty_n !== 1'b0) $display("FAIL rmid_empty_n: got %b want 0", out_empty_n); else passes++;
        drive(1'b1, 1'b1, 32'hA1, 1'b0);
        drive(1'b1, 1'b1, 32'hA2, 1'b0);
        drive(1'b1, 1'b1, 32'hA3, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b1);
        checks++; if (out_empty_n !== 1'b1) $display("FAIL rmid_valid: got %b want 1", out_empty_n); else passes++;
        checks++; if (out_dout !== exp_w) $display("FAIL rmid_dout: got %h want %h", out_dout, exp_w); else passes++;
        checks++; if (out_count !== CW'(4)) $display("FAIL rmid_count: got %0d want 4", out_count); else passes++;
        drive(1'b1, 1'b0, '0, 1'b0);
    endtask

`ifdef RELAY_UPSIZER_EOT_EN
    task automatic test_eot();
        logic [OW-1:0] exp_w;
        exp_w = {32'h0, 32'h0, 32'h80000002, 32'h1};
        drive(1'b1, 1'b1, 32'h1, 1'b0);
        drive(1'b1, 1'b1, 32'h80000002, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b1);
        checks++; if (out_empty_n !== 1'b1) $display("FAIL eot_valid: got %b want 1", out_empty_n); else passes++;
        checks++; if (out_dout !== exp_w) $display("FAIL eot_dout: got %h want %h", out_dout, exp_w); else passes++;
        checks++; if (out_count !== CW'(2)) $display("FAIL eot_count: got %0d want 2", out_count); else passes++;
        drive(1'b1, 1'b0, '0, 1'b0);
        narrow_q.delete();
        wide_q.delete();
    endtask
`endif

    task automatic test_random();
        int sent, cyc, rds, bad;
        sent = 0; cyc = 0; rds = 0; bad = 0;
        while (sent < 10000 && cyc < 60000) begin
            drive(1'b1, ($urandom_range(3) != 0), rword(), ($urandom_range(3) != 0));
            cyc++;
            if (acc_s) sent++;
            if (rd_s) begin
                rds++;
                checks++;
                if (!rd_known || out_dout !== rd_exp || out_count !== CW'(R)) begin
                    if (bad < 10) $display("FAIL rand_word%0d: got %h/%0d want %h/%0d", rds, out_dout, out_count, rd_exp, R);
                    bad++;
                end else passes++;
            end
        end
        checks++; if (sent != 10000) $display("FAIL rand_timeout: sent %0d want 10000", sent); else passes++;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 1'b0, '0, 1'b1);
            if (rd_s) begin
                rds++;
                checks++;
                if (!rd_known || out_dout !== rd_exp) $display("FAIL rand_drain: got %h want %h", out_dout, rd_exp); else passes++;
            end
        end
        checks++; if (rds != 2500) $display("FAIL rand_word_count: got %0d want 2500", rds); else passes++;
        checks++; if (wide_q.size() != 0 || narrow_q.size() != 0) $display("FAIL rand_leftover: got %0d/%0d want 0/0", wide_q.size(), narrow_q.size()); else passes++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef RELAY_UPSIZER_EOT_EN
        test_eot();
`endif
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/relay_upsizer.md
# relay_upsizer

Stream width converter that sits directly downstream of a relay station. It drains the relay station's first-word fall-through (FWFT) read port, packing `RATIO` consecutive narrow words into one wide word. It presents that wide word on its own FWFT port to the consuming kernel. It sustains one narrow word per cycle, so a wide output is available every `RATIO` cycles with no bubbles while the output is being read.

## Interface
- `IN_WIDTH`, 32, narrow word width. With `RELAY_UPSIZER_EOT_EN` defined, bit `IN_WIDTH-1` is the end-of-transfer (EOT) flag.
- `RATIO`, 4, narrow words per wide word; legal values are 2..64.
- `OUT_WIDTH`, derived localparam `IN_WIDTH*RATIO`; not overridable.
- `CNT_WIDTH`, derived localparam `$clog2(RATIO+1)`.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  sole clock; all state is updated on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `in_empty_n`  in  1  upstream FWFT has data.
- `in_read`  out  1  combinational acknowledge; consumes `in_dout` this cycle.
- `in_dout`  in  `IN_WIDTH`  upstream head word.
- `out_empty_n`  out  1  wide word valid.
- `out_read`  in  1  downstream consumes `out_dout`.
- `out_dout`  out  `OUT_WIDTH`  packed word; lane 0 occupies bits `[IN_WIDTH-1:0]`.
- `out_count`  out  `CNT_WIDTH`  number of valid lanes in `out_dout`.

## Operation
- State:
  - `lane` counter (0..RATIO-1).
  - Accumulator holding lanes 0..RATIO-2.
  - Output register: `out_dout`, `out_count`, `out_empty_n`.
- `stall` = (`lane`==RATIO-1) & `out_empty_n` & ~`out_read`.
- `in_read` = `reset_n` & `in_empty_n` & ~`stall`. An accept is `in_read` high.
- On an accept with `lane` < RATIO-1:
  - write `in_dout` into accumulator lane `lane`;
  - increment `lane`.
- On an accept with `lane` == RATIO-1:
  - load the output register with {`in_dout`, accumulator};
  - set `out_count` to RATIO and `out_empty_n` to 1;
  - set `lane` to 0.
- The accumulator is not cleared on wrap; stale lanes are overwritten before reuse.
- When `out_read` & `out_empty_n` and no load occurs in the same cycle, `out_empty_n` goes to 0. `out_dout` holds its last value.
- When a load and `out_read` occur in the same cycle, the register reloads and `out_empty_n` stays 1. This is the full-throughput case.
- `out_read` is ignored while `out_empty_n` is 0.
- `in_dout` is sampled only on an accept; its value is don't-care otherwise.
- Reset values:
  - `out_empty_n`=0, `out_dout`=0, `out_count`=0;
  - `lane`=0, accumulator=0;
  - `in_read`=0 for the whole reset cycle.
- Reset asserted mid-packet discards the partial lanes and any unread output word; the next accepted word after reset goes to lane 0.

## Timing
- Latency: the final lane is accepted in cycle t; `out_empty_n` is 1 in cycle t+1.
- Throughput: one input per cycle whenever `in_empty_n` and the output drain keep pace. A stall occurs only when the final lane is ready and the output register is occupied and not being read.
- `in_read` depends combinationally on `in_empty_n`, `out_read` and internal registers only. It has no path from `in_dout`.
- Every output except `in_read` is a register.

## Configuration
- `RELAY_UPSIZER_EOT_EN` defined:
  - An accept whose `in_dout[IN_WIDTH-1]` is 1, with `lane`=k, loads the output register immediately. Lanes 0..k-1 come from the accumulator, lane k is `in_dout`, lanes above k are 0.
  - `out_count` is k+1 and `lane` resets to 0.
  - The EOT bit is kept in the data.
  - `stall` then also applies to any EOT word: `out_empty_n` & ~`out_read` & EOT.
- Not defined: bit `IN_WIDTH-1` is plain data, and `out_count` is always RATIO after the first load.

## Structure
- Shared package `relay_pkg`:
  - `clog2` helper function;
  - default `IN_WIDTH`/`RATIO` constants;
  - `RATIO` legality check, used by elaboration assertions.
- One sub-module, `relay_upsizer_acc`:
  - lane counter plus accumulator;
  - outputs the completed wide vector and the "complete" strobe.
- Top level owns the output register and the handshake.

## Test plan
- Reset, then `in_empty_n`=1 with words 0x11, 0x22, 0x33, 0x44 and `out_read`=1 → `out_dout`=0x00000044_00000033_00000022_00000011 in the cycle after 0x44 is accepted, `out_count`=4.
- Continuous input of 16 words with `out_read` held at 1 → `in_read` is never deasserted, and 4 wide words appear spaced exactly 4 cycles apart.
- `out_read`=0 while 8 words are offered → the first wide word is held, 3 more words are accepted, `in_read` drops on the 8th word; raising `out_read` accepts the 8th word that same cycle.
- `reset_n` pulled low after 2 of 4 lanes are accepted → `out_empty_n`=0, and the next 4 words form a clean wide word with the first post-reset word in lane 0.
- `RELAY_UPSIZER_EOT_EN` defined: words 0x1, then 0x80000002 → `out_dout` lanes = {0, 0, 0x80000002, 0x1}, `out_count`=2.
- Random `in_empty_n`/`out_read` toggling over 10k words → the wide stream matches the reference-model packing, with no loss or duplication.
